mips_mc_ctrl: RTL and testbench

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

---
 rtl/mips_mc_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// bounded memory handshakes, a sticky FAULT state and a retired-instruction counter.
module mips_mc_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [11:0] alu_control,
    output logic        alu_src_imm,
    input  logic        alu_zero,
    output logic        ir_load,
    output logic        pc_load,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [1:0]  pc_src,
    output logic        fault,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [11:0] ALU_ADD_IMM = 12'b001000000000;
    localparam logic [7:0]  WAIT_LAST   = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [5:0]  r_opcode;
    logic [5:0]  r_funct;
    logic [7:0]  r_wait_cnt;
    logic [31:0] r_retired;

    state_t      w_next_state;
    logic [5:0]  w_dec_op;
    logic        w_wait_last;
    logic        w_wait_inc;
    logic        w_wait_clr;
    logic        w_retire;
    logic        w_unused_instr;

    assign w_dec_op       = instr[31:26];
    assign w_wait_last    = (r_wait_cnt == WAIT_LAST);
    assign w_unused_instr = ^instr[25:6];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an ack in the last allowed wait cycle beats the timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (imem_ack)
                    w_next_state = ST_DECODE;
                else if (w_wait_last)
                    w_next_state = ST_FAULT;
            end
            ST_DECODE: begin
                case (w_dec_op)
                    OP_J:                                 w_next_state = ST_FETCH;
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: w_next_state = ST_EXEC;
                    default:                              w_next_state = ST_FAULT;
                endcase
            end
            ST_EXEC: begin
                case (r_opcode)
                    OP_RTYPE, OP_ADDI: w_next_state = ST_WB;
                    OP_LW, OP_SW:      w_next_state = ST_MEM;
                    OP_BEQ:            w_next_state = ST_FETCH;
                    default:           w_next_state = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack)
                    w_next_state = (r_opcode == OP_LW) ? ST_WB : ST_FETCH;
                else if (w_wait_last)
                    w_next_state = ST_FAULT;
            end
            ST_WB:    w_next_state = ST_FETCH;
            ST_FAULT: w_next_state = ST_FAULT;
            default:  w_next_state = ST_FAULT;
        endcase
    end

    // Outputs; forced quiet while reset is held so strobes drop immediately
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_control = 12'h000;
        alu_src_imm = 1'b0;
        ir_load     = 1'b0;
        pc_load     = 1'b0;
        reg_we      = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        pc_src      = 2'd0;
        fault       = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_load = 1'b1;
                        pc_load = 1'b1;
                        pc_src  = 2'd0;
                    end
                end
                ST_DECODE: begin
                    if (w_dec_op == OP_J) begin
                        pc_load = 1'b1;
                        pc_src  = 2'd2;
                    end
                end
                ST_EXEC: begin
                    case (r_opcode)
                        OP_RTYPE: alu_control = {6'b000000, r_funct};
                        OP_ADDI, OP_LW, OP_SW: begin
                            alu_control = ALU_ADD_IMM;
                            alu_src_imm = 1'b1;
                        end
                        OP_BEQ: begin
                            alu_control = ALU_ADD_IMM;
                            if (alu_zero) begin
                                pc_load = 1'b1;
                                pc_src  = 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (r_opcode == OP_SW);
                end
                ST_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = (r_opcode == OP_RTYPE);
                    mem_to_reg = (r_opcode == OP_LW);
                end
                ST_FAULT: fault = 1'b1;
                default:  ;
            endcase
        end
    end

    assign state   = r_state;
    assign retired = r_retired;

    assign w_wait_clr = (w_next_state != r_state) &&
                        ((w_next_state == ST_FETCH) || (w_next_state == ST_MEM));
    assign w_wait_inc = ((r_state == ST_FETCH) && !imem_ack) ||
                        ((r_state == ST_MEM) && !dmem_ack);

    // Instruction completion points: each instruction class retires exactly once
    assign w_retire = (r_state == ST_WB) ||
                      ((r_state == ST_MEM) && dmem_ack && (r_opcode == OP_SW)) ||
                      ((r_state == ST_EXEC) && (r_opcode == OP_BEQ)) ||
                      ((r_state == ST_DECODE) && (w_dec_op == OP_J));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode   <= 6'd0;
            r_funct    <= 6'd0;
            r_wait_cnt <= 8'd0;
            r_retired  <= 32'd0;
        end else begin
            if (r_state == ST_DECODE) begin
                r_opcode <= instr[31:26];
                r_funct  <= instr[5:0];
            end
            if (w_wait_clr)
                r_wait_cnt <= 8'd0;
            else if (w_wait_inc)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_retire)
                r_retired <= r_retired + 32'd1;
        end
    end

    a_fault_sticky: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == ST_FAULT) |=> (r_state == ST_FAULT));
    a_fault_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == ST_FAULT) |-> !(imem_req || dmem_req || ir_load || pc_load || reg_we));
    a_req_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_req && dmem_req));

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: each driven cycle queues its expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_mips_mc_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        imem_req, imem_ack;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [11:0] alu_control;
    logic        alu_src_imm, alu_zero;
    logic        ir_load, pc_load, reg_we, reg_dst, mem_to_reg;
    logic [1:0]  pc_src;
    logic        fault;
    logic [2:0]  state;
    logic [31:0] retired;

    mips_mc_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_control(alu_control), .alu_src_imm(alu_src_imm), .alu_zero(alu_zero),
        .ir_load(ir_load), .pc_load(pc_load), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .pc_src(pc_src), .fault(fault), .state(state),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [9:0] IREQ = 10'b10_0000_0000;
    localparam logic [9:0] IRL  = 10'b01_0000_0000;
    localparam logic [9:0] PCL  = 10'b00_1000_0000;
    localparam logic [9:0] DREQ = 10'b00_0100_0000;
    localparam logic [9:0] DWE  = 10'b00_0010_0000;
    localparam logic [9:0] SRCI = 10'b00_0001_0000;
    localparam logic [9:0] RWE  = 10'b00_0000_1000;
    localparam logic [9:0] RDST = 10'b00_0000_0100;
    localparam logic [9:0] M2R  = 10'b00_0000_0010;
    localparam logic [9:0] FLT  = 10'b00_0000_0001;
    localparam logic [9:0] NONE = 10'b00_0000_0000;

    typedef struct {
        string       tag;
        logic [26:0] vec;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ret  = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [26:0] obs;
            e   = sb_q.pop_front();
            obs = {state, imem_req, ir_load, pc_load, dmem_req, dmem_we, alu_src_imm,
                   reg_we, reg_dst, mem_to_reg, fault, pc_src, alu_control};
            check(e.tag, {5'd0, obs}, {5'd0, e.vec});
            check({e.tag, "_ret"}, retired, e.ret);
        end
    end

    // One clock cycle: drive inputs, queue what the DUT must show during this cycle
    task automatic step(input string tag, input logic ia, input logic da, input logic z,
                        input logic [2:0] st, input logic [9:0] sb, input logic [1:0] ps,
                        input logic [11:0] alu, input bit ret);
        exp_t e;
        imem_ack = ia;
        dmem_ack = da;
        alu_zero = z;
        e.tag = tag;
        e.vec = {st, sb, ps, alu};
        e.ret = exp_ret;
        sb_q.push_back(e);
        if (ret) exp_ret = exp_ret + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [31:0] ins, input int waits, input logic stray);
        instr = ins;
        for (int i = 0; i < waits; i++)
            step({tag, "_fw"}, 1'b0, stray, 1'b0, 3'd0, IREQ, 2'd0, 12'h000, 1'b0);
        step({tag, "_fa"}, 1'b1, 1'b0, 1'b0, 3'd0, IREQ | IRL | PCL, 2'd0, 12'h000, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_state"}, {29'd0, state}, 32'd0);
        check({tag, "_ireq"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_dreq"}, {31'd0, dmem_req}, 32'd0);
        check({tag, "_fault"}, {31'd0, fault}, 32'd0);
        check({tag, "_alu"}, {20'd0, alu_control}, 32'd0);
        check({tag, "_ret"}, retired, 32'd0);
        exp_ret = 32'd0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b1;
        instr    = 32'd0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        alu_zero = 1'b0;
        #2;
        do_reset("rst0");

        // addi, ack on first request cycle
        fetch("addi", 32'h2008_0005, 0, 1'b0);
        step("addi_dec", 0, 0, 0, 3'd1, NONE, 2'd0, 12'h000, 0);
        step("addi_ex",  0, 0, 0, 3'd2, SRCI, 2'd0, 12'h200, 0);
        step("addi_wb",  0, 0, 0, 3'd4, RWE,  2'd0, 12'h000, 1);

        // lw, stray dmem_ack while dmem_req is low, dmem_ack on the 4th MEM cycle
        fetch("lw", 32'h8C09_0004, 1, 1'b1);
        step("lw_dec", 0, 1, 0, 3'd1, NONE, 2'd0, 12'h000, 0);
        step("lw_ex",  0, 1, 0, 3'd2, SRCI, 2'd0, 12'h200, 0);
        for (int i = 0; i < 3; i++)
            step("lw_mw", 1, 0, 0, 3'd3, DREQ, 2'd0, 12'h000, 0);
        step("lw_ma", 0, 1, 0, 3'd3, DREQ, 2'd0, 12'h000, 0);
        step("lw_wb", 0, 0, 0, 3'd4, RWE | M2R, 2'd0, 12'h000, 1);

        // sw, same delay, retires on the ack and skips WB
        fetch("sw", 32'hAD09_0004, 0, 1'b0);
        step("sw_dec", 0, 0, 0, 3'd1, NONE, 2'd0, 12'h000, 0);
        step("sw_ex",  0, 0, 0, 3'd2, SRCI, 2'd0, 12'h200, 0);
        for (int i = 0; i < 3; i++)
            step("sw_mw", 0, 0, 0, 3'd3, DREQ | DWE, 2'd0, 12'h000, 0);
        step("sw_ma", 0, 1, 0, 3'd3, DREQ | DWE, 2'd0, 12'h000, 1);

        // beq taken and not taken
        fetch("beqt", 32'h1109_0003, 0, 1'b0);
        step("beqt_dec", 0, 0, 1, 3'd1, NONE, 2'd0, 12'h000, 0);
        step("beqt_ex",  0, 0, 1, 3'd2, PCL,  2'd1, 12'h200, 1);
        fetch("beqn", 32'h1109_0003, 0, 1'b0);
        step("beqn_dec", 0, 0, 1, 3'd1, NONE, 2'd0, 12'h000, 0);
        step("beqn_ex",  0, 0, 0, 3'd2, NONE, 2'd0, 12'h200, 1);

        // R-type add (funct 0x20)
        fetch("rt", 32'h0109_5020, 0, 1'b0);
        step("rt_dec", 0, 0, 0, 3'd1, NONE, 2'd0, 12'h000, 0);
        step("rt_ex",  0, 0, 0, 3'd2, NONE, 2'd0, 12'h020, 0);
        step("rt_wb",  0, 0, 0, 3'd4, RWE | RDST, 2'd0, 12'h000, 1);

        // j retires in DECODE
        fetch("j", 32'h0800_0010, 0, 1'b0);
        step("j_dec", 0, 0, 0, 3'd1, PCL, 2'd2, 12'h000, 1);

        // fetch ack in the last allowed (4th) cycle still wins
        fetch("late", 32'h2008_0005, 3, 1'b0);
        step("late_dec", 0, 0, 0, 3'd1, NONE, 2'd0, 12'h000, 0);
        step("late_ex",  0, 0, 0, 3'd2, SRCI, 2'd0, 12'h200, 0);
        step("late_wb",  0, 0, 0, 3'd4, RWE,  2'd0, 12'h000, 1);
        step("late_f",   0, 0, 0, 3'd0, IREQ, 2'd0, 12'h000, 0);

        // illegal opcode 0x3F -> sticky FAULT, acks ignored
        fetch("ill", 32'hFC00_0000, 0, 1'b0);
        step("ill_dec", 0, 0, 0, 3'd1, NONE, 2'd0, 12'h000, 0);
        for (int i = 0; i < 3; i++)
            step("ill_flt", 1, 1, 1, 3'd7, FLT, 2'd0, 12'h000, 0);
        do_reset("rst1");

        // fetch timeout after exactly 4 request cycles
        instr = 32'h2008_0005;
        for (int i = 0; i < 4; i++)
            step("to_fw", 0, 0, 0, 3'd0, IREQ, 2'd0, 12'h000, 0);
        step("to_flt",  0, 0, 0, 3'd7, FLT, 2'd0, 12'h000, 0);
        step("to_flt2", 1, 0, 0, 3'd7, FLT, 2'd0, 12'h000, 0);
        do_reset("rst2");

        // reset in the middle of a load
        fetch("lwr", 32'h8C09_0004, 0, 1'b0);
        step("lwr_dec", 0, 0, 0, 3'd1, NONE, 2'd0, 12'h000, 0);
        step("lwr_ex",  0, 0, 0, 3'd2, SRCI, 2'd0, 12'h200, 0);
        step("lwr_mw",  0, 0, 0, 3'd3, DREQ, 2'd0, 12'h000, 0);
        check("lwr_dreq_pre", {31'd0, dmem_req}, 32'd1);
        do_reset("rst3");
        step("post_f", 0, 0, 0, 3'd0, IREQ, 2'd0, 12'h000, 0);
        fetch("post", 32'h0800_0010, 0, 1'b0);
        step("post_dec", 0, 0, 0, 3'd1, PCL, 2'd2, 12'h000, 1);
        step("post_f2",  0, 0, 0, 3'd0, IREQ, 2'd0, 12'h000, 0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
